// File: rtl/centimos_euros_seq.sv
// centimos_euros_seq: splits a price in centimos into euros/cents via restoring division by 100, one quotient bit per clock.
// Optional macro ARREDONDAMENTO_EN adds the registered half-up rounded output euros_arred.
module centimos_euros_seq #(
    parameter int unsigned W_CENT = 14,
    parameter int unsigned W_EUR  = W_CENT - 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_CENT-1:0] centimos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_EUR-1:0]  euros,
    output logic [6:0]        cents,
`ifdef ARREDONDAMENTO_EN
    output logic [W_EUR:0]    euros_arred,
`endif
    output logic              busy
);

    localparam int unsigned W_CNT = $clog2(W_CENT);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [W_CENT-1:0]   divd_q, divd_d;
    logic [6:0]          rem_q, rem_d;
    logic [W_EUR-1:0]    quot_q, quot_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [W_EUR-1:0]    euros_q, euros_d;
    logic [6:0]          cents_q, cents_d;
`ifdef ARREDONDAMENTO_EN
    logic [W_EUR:0]      arred_q, arred_d;
`endif

    logic [7:0]          r_sh;
    logic                r_ge;
    logic [6:0]          r_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            divd_q  <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            euros_q <= '0;
            cents_q <= '0;
`ifdef ARREDONDAMENTO_EN
            arred_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            divd_q  <= divd_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            euros_q <= euros_d;
            cents_q <= cents_d;
`ifdef ARREDONDAMENTO_EN
            arred_q <= arred_d;
`endif
        end
    end

    // Remainder stays below 100 after every step, so 7 stored bits suffice; the
    // quotient register is W_EUR wide because any higher quotient bits are always zero.
    always_comb begin
        r_sh    = {rem_q, divd_q[W_CENT-1]};
        r_ge    = (r_sh >= 8'd100);
        r_sub   = 7'(r_sh - 8'd100);

        state_d = state_q;
        divd_d  = divd_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        euros_d = euros_q;
        cents_d = cents_q;
`ifdef ARREDONDAMENTO_EN
        arred_d = arred_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    divd_d  = centimos;
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = W_CNT'(W_CENT - 1);
                    state_d = DIV;
                end
            end
            DIV: begin
                divd_d = {divd_q[W_CENT-2:0], 1'b0};
                rem_d  = r_ge ? r_sub : r_sh[6:0];
                quot_d = {quot_q[W_EUR-2:0], r_ge};
                if (cnt_q == '0) begin
                    euros_d = quot_d;
                    cents_d = rem_d;
`ifdef ARREDONDAMENTO_EN
                    arred_d = {1'b0, quot_d} + (W_EUR+1)'(rem_d >= 7'd50);
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - W_CNT'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == DIV);
    assign out_valid = (state_q == DONE);
    assign euros     = euros_q;
    assign cents     = cents_q;
`ifdef ARREDONDAMENTO_EN
    assign euros_arred = arred_q;
`endif

endmodule

// File: tb/tb_centimos_euros_seq.sv
// Directed and random checks of centimos_euros_seq: latency, results, backpressure, async reset, rounding.
module tb_centimos_euros_seq;

    localparam int unsigned W  = 14;
    localparam int unsigned WE = W - 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rst_r;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  centimos;
    logic [WE-1:0] euros;
    logic [6:0]    cents;
`ifdef ARREDONDAMENTO_EN
    logic [WE:0]   euros_arred;
`endif

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    centimos_euros_seq #(.W_CENT(W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .centimos   (centimos),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .euros      (euros),
        .cents      (cents),
`ifdef ARREDONDAMENTO_EN
        .euros_arred(euros_arred),
`endif
        .busy       (busy)
    );

    task automatic check(input string tag, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT in IDLE.
    task automatic convert(input string tag, input int unsigned v,
                           input int unsigned exp_e, input int unsigned exp_c);
        int unsigned lat;
        centimos = W'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " in_ready_low"}, in_ready, 0);
        check({tag, " busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < W + 4) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, W);
        check({tag, " euros"}, euros, exp_e);
        check({tag, " cents"}, cents, exp_c);
        check({tag, " busy_done"}, busy, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, out_valid, 0);
        check({tag, " in_ready_back"}, in_ready, 1);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int unsigned RW = (g == 0) ? 8 : ((g == 1) ? 14 : 20);
        logic          iv, ir, ov, ordy, bz, done;
        logic [RW-1:0] c;
        logic [RW-7:0] e;
        logic [6:0]    ct;
`ifdef ARREDONDAMENTO_EN
        logic [RW-6:0] ea;
`endif

        centimos_euros_seq #(.W_CENT(RW)) u_dut (
            .clk        (clk),
            .rst_n      (rst_r),
            .in_valid   (iv),
            .in_ready   (ir),
            .centimos   (c),
            .out_valid  (ov),
            .out_ready  (ordy),
            .euros      (e),
            .cents      (ct),
`ifdef ARREDONDAMENTO_EN
            .euros_arred(ea),
`endif
            .busy       (bz)
        );

        initial begin
            int unsigned v, lat;
            string t;
            t    = $sformatf("rnd%0d", RW);
            done = 1'b0;
            iv   = 1'b0;
            ordy = 1'b0;
            c    = '0;
            wait (rst_r === 1'b1);
            tick();
            for (int n = 0; n < 600; n++) begin
                repeat ($urandom_range(0, 3)) tick();
                v = $urandom % (32'd1 << RW);
                if (n % 50 == 0) v = (32'd1 << RW) - 1;
                if (n % 50 == 1) v = 0;
                check({t, " in_ready"}, ir, 1);
                c  = RW'(v);
                iv = 1'b1;
                tick();
                lat = 0;
                while (!ov && lat < RW + 4) begin
                    iv = 1'($urandom_range(0, 1));
                    c  = RW'($urandom);
                    tick();
                    lat++;
                end
                iv = 1'b0;
                check({t, " latency"}, lat, RW);
                check({t, " euros"}, e, v / 100);
                check({t, " cents"}, ct, v % 100);
`ifdef ARREDONDAMENTO_EN
                check({t, " arred"}, ea, v / 100 + (((v % 100) >= 50) ? 1 : 0));
`endif
                repeat ($urandom_range(0, 3)) tick();
                check({t, " held_valid"}, ov, 1);
                ordy = 1'b1;
                tick();
                ordy = 1'b0;
                check({t, " out_valid_drop"}, ov, 0);
            end
            done = 1'b1;
        end
    end

    initial begin
        int unsigned guard, saw;
        rst_n     = 1'b0;
        rst_r     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        centimos  = '0;
        repeat (3) tick();
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst euros", euros, 0);
        check("rst cents", cents, 0);
        rst_n = 1'b1;
        rst_r = 1'b1;
        tick();

        convert("basic250", 250, 2, 50);
        convert("zero", 0, 0, 0);
        convert("c99", 99, 0, 99);
        convert("c100", 100, 1, 0);
        convert("max", 16383, 163, 83);

        // Backpressure: result held 20 cycles while new inputs are offered and ignored.
        centimos = W'(1234);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < W + 4) begin
            tick();
            guard++;
        end
        check("bp latency", guard, W);
        for (int i = 0; i < 20; i++) begin
            centimos = W'(i * 311 + 5);
            in_valid = i[0];
            tick();
            check("bp out_valid", out_valid, 1);
            check("bp euros", euros, 12);
            check("bp cents", cents, 34);
            check("bp in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release", out_valid, 0);
        check("bp idle", in_ready, 1);
        tick();
        tick();
        check("bp no_accept busy", busy, 0);
        check("bp no_accept ready", in_ready, 1);
        check("bp euros_kept", euros, 12);

        // Asynchronous reset during the seventh DIV cycle.
        centimos = W'(5000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst out_valid", out_valid, 0);
        check("mid_rst euros", euros, 0);
        check("mid_rst cents", cents, 0);
        check("mid_rst busy", busy, 0);
        check("mid_rst in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        saw = 0;
        repeat (W + 2) begin
            tick();
            if (out_valid) saw = 1;
        end
        check("mid_rst no_stale", saw, 0);
        convert("after_rst777", 777, 7, 77);

`ifdef ARREDONDAMENTO_EN
        convert("r249", 249, 2, 49);
        check("arred249", euros_arred, 2);
        convert("r250", 250, 2, 50);
        check("arred250", euros_arred, 3);
        convert("r16383", 16383, 163, 83);
        check("arred16383", euros_arred, 164);
`endif

        guard = 0;
        while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && guard < 80000) begin
            tick();
            guard++;
        end
        check("rnd completed", {g_rnd[0].done, g_rnd[1].done, g_rnd[2].done}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
